// File: rtl/cska_mw_seq.sv
// Multi-word sequential adder: one N-bit carry-skip pass per cycle over WORDS words,
// with a valid/ready request side and a held result in DONE.

module cska_top #(
  parameter int N          = 4,
  parameter int BLOCK_SIZE = 2
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  localparam int NBLK  = (N + BLOCK_SIZE - 1) / BLOCK_SIZE;
  localparam int W_PAD = NBLK * BLOCK_SIZE;

  logic [W_PAD-1:0] a_pad;
  logic [W_PAD-1:0] b_pad;
  logic [W_PAD-1:0] sum_pad;
  logic             c;
  logic             blk_cin;
  logic             blk_p;
  logic             p;
  logic             g;

  // Padding bits propagate (p=1, g=0) so a partial last block passes its carry through.
  always_comb begin
    a_pad          = '1;
    a_pad[N-1:0]   = A;
    b_pad          = '0;
    b_pad[N-1:0]   = B;
    sum_pad        = '0;
    c              = Cin;
    blk_cin        = 1'b0;
    blk_p          = 1'b0;
    p              = 1'b0;
    g              = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      blk_cin = c;
      blk_p   = 1'b1;
      for (int j = 0; j < BLOCK_SIZE; j++) begin
        p                         = a_pad[k*BLOCK_SIZE+j] ^ b_pad[k*BLOCK_SIZE+j];
        g                         = a_pad[k*BLOCK_SIZE+j] & b_pad[k*BLOCK_SIZE+j];
        sum_pad[k*BLOCK_SIZE+j]   = p ^ c;
        c                         = g | (p & c);
        blk_p                     = blk_p & p;
      end
      c = blk_p ? blk_cin : c;
    end
    Sum  = sum_pad[N-1:0];
    Cout = c;
  end

endmodule

module cska_mw_seq #(
  parameter int N          = 4,
  parameter int BLOCK_SIZE = 2,
  parameter int WORDS      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] A,
  input  logic [N*WORDS-1:0] B,
  input  logic               Cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] Sum,
  output logic               Cout,
  output logic               busy
);

  localparam int W     = N * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [N-1:0]       add_a;
  logic [N-1:0]       add_b;
  logic [N-1:0]       add_sum;
  logic               add_cout;
  int                 idx_i;
  logic               accept;
  logic               last_pass;

  assign idx_i     = int'(idx_q);
  assign add_a     = a_q[idx_i*N +: N];
  assign add_b     = b_q[idx_i*N +: N];
  assign accept    = in_valid && in_ready;
  assign last_pass = (idx_q == IDX_W'(WORDS - 1));

  cska_top #(
    .N          (N),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_adder (
    .A    (add_a),
    .B    (add_b),
    .Cin  (carry_q),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_i*N +: N] = add_sum;
        carry_d             = add_cout;
        if (last_pass) begin
          cout_d  = add_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  // Operand holding registers carry data only; they are always reloaded before use.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign Sum       = sum_q;
  assign Cout      = cout_q;

endmodule

// File: tb/tb_cska_mw_seq.sv
// Directed bench for cska_mw_seq (N=4, BLOCK_SIZE=2, WORDS=4) using immediate assertions.

module tb_cska_mw_seq;

  localparam int N     = 4;
  localparam int BS    = 2;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  cska_mw_seq #(.N(N), .BLOCK_SIZE(BS), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble the inputs after acceptance, and wait for DONE.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic [W-1:0] exp_s, input logic exp_c);
    int n;
    A = a; B = b; Cin = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; A = ~a; B = ~b; Cin = ~ci;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, WORDS);
    chk({tag, "_sum"}, 32'(Sum), 32'(exp_s));
    chk({tag, "_cout"}, 32'(Cout), 32'(exp_c));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ov_after"}, 32'(out_valid), 32'd0);
    chk({tag, "_ir_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0]  ra, rb;
    logic          rc;
    logic [W:0]    e;
    int            n, acc, prev_acc;

    // Reset state while rst is held
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(Sum), 32'd0);
    chk("rst_cout", 32'(Cout), 32'd0);
    #9 rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    run_op("zeros", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    consume("zeros");
    run_op("ripple1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    consume("ripple1");
    run_op("ripple2", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    consume("ripple2");
    run_op("cin", 16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0);
    consume("cin");
    chk("idle_hold_sum", 32'(Sum), 32'h0101);
    chk("idle_hold_cout", 32'(Cout), 32'd0);

    // Backpressure in DONE with noisy inputs
    run_op("bp", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
    for (int i = 0; i < 5; i++) begin
      A = 16'($urandom); B = 16'($urandom); Cin = i[0]; in_valid = i[0];
      @(posedge clk); #1;
      chk("bp_sum", 32'(Sum), 32'h2345);
      chk("bp_cout", 32'(Cout), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("consume_no_accept_busy", 32'(busy), 32'd0);
    chk("consume_no_accept_ir", 32'(in_ready), 32'd1);

    // Reset asserted on the second RUN cycle
    A = 16'h8888; B = 16'h8888; Cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    chk("mid_rst_ir", 32'(in_ready), 32'd0);
    chk("mid_rst_sum", 32'(Sum), 32'd0);
    chk("mid_rst_cout", 32'(Cout), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rel_ir", 32'(in_ready), 32'd1);
    run_op("after_rst", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    consume("after_rst");

    // Back-to-back random requests with out_ready held high
    out_ready = 1'b1;
    prev_acc  = 0;
    for (int k = 0; k < 5; k++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      e  = {1'b0, ra} + {1'b0, rb} + 17'(rc);
      A = ra; B = rb; Cin = rc; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("b2b_ready_wait", 32'(n < 20), 32'd1);
      @(posedge clk); #1;
      acc = cyc;
      if (k > 0) chk("b2b_spacing", acc - prev_acc, WORDS + 2);
      prev_acc = acc;
      n = 0;
      while (!out_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("b2b_latency", n, WORDS);
      chk("b2b_sum", 32'(Sum), 32'(e[W-1:0]));
      chk("b2b_cout", 32'(Cout), 32'(e[W]));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("end_idle", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
